sys_mem_ctrl: RTL and testbench

System memory controller: the memory-subsystem side of the memory interface unit's request/response handshake. Accepts one read or write request at a time from the memory interface unit, services it against a 16 KByte byte-addressed storage array after a fixed latency, and returns `mem_resp` under a four-phase handshake. Reads return 8 bits; writes store 16 bits as two consecutive bytes.

---
 rtl/sys_mem_if.sv | 24 ++
 rtl/sys_mem_ctrl.sv | 110 +++++++++++
 tb/tb_sys_mem_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sys_mem_if.sv
// Request/response handshake between the memory interface unit (master)
// and the system memory controller (slave).
interface sys_mem_if #(
   parameter int ADDR_W = 14
);
   logic              read_req;
   logic              write_req;
   logic [ADDR_W-1:0] addrin;
   logic [15:0]       datain;
   logic              mem_resp;
   logic [7:0]        dataout;
   logic              busy;
   logic              err;

   modport master (
      output read_req, write_req, addrin, datain,
      input  mem_resp, dataout, busy, err
   );

   modport slave (
      input  read_req, write_req, addrin, datain,
      output mem_resp, dataout, busy, err
   );
endinterface

// File: rtl/sys_mem_ctrl.sv
// System memory controller: one request at a time against a byte-addressed
// array, fixed latency, four-phase mem_resp handshake.
module sys_mem_ctrl #(
   parameter int ADDR_W = 14,
   parameter int RD_LAT = 3,
   parameter int WR_LAT = 3
) (
   input  logic     clk,
   input  logic     reset_n,
   sys_mem_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
   localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);

   logic [7:0] mem [0:(1 << ADDR_W) - 1];

   state_t            state, state_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic              op_wr, op_wr_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt, addr_hi;
   logic [15:0]       wdata, wdata_nxt;
   logic              resp, resp_nxt;
   logic              err, err_nxt;
   logic              acc_rd, acc_wr;
   logic [7:0]        dout;
   logic              req_held;

   assign addr_hi  = addr + {{(ADDR_W-1){1'b0}}, 1'b1};
   // Only the accepted request line ends RESP; the other one is ignored.
   assign req_held = op_wr ? bus.write_req : bus.read_req;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      op_wr_nxt = op_wr;
      addr_nxt  = addr;
      wdata_nxt = wdata;
      resp_nxt  = resp;
      err_nxt   = 1'b0;
      acc_rd    = 1'b0;
      acc_wr    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.read_req ^ bus.write_req) begin
               op_wr_nxt = bus.write_req;
               addr_nxt  = bus.addrin;
               wdata_nxt = bus.datain;
               cnt_nxt   = bus.write_req ? WR_CNT : RD_CNT;
               state_nxt = ACCESS;
            end else if (bus.read_req && bus.write_req) begin
               err_nxt = 1'b1;
            end
         end
         ACCESS: begin
            if (cnt == 4'd0) begin
               acc_wr    = op_wr;
               acc_rd    = !op_wr;
               resp_nxt  = 1'b1;
               state_nxt = RESP;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         RESP: begin
            if (!req_held) begin
               resp_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
         op_wr <= 1'b0;
         addr  <= '0;
         wdata <= 16'h0000;
         resp  <= 1'b0;
         err   <= 1'b0;
         dout  <= 8'h00;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         op_wr <= op_wr_nxt;
         addr  <= addr_nxt;
         wdata <= wdata_nxt;
         resp  <= resp_nxt;
         err   <= err_nxt;
         if (acc_rd) dout <= mem[addr];
      end
   end

   // Storage is never reset; a reset edge suppresses a pending write.
   always_ff @(posedge clk) begin
      if (reset_n && acc_wr) begin
         mem[addr]    <= wdata[7:0];
         mem[addr_hi] <= wdata[15:8];
      end
   end

   assign bus.mem_resp = resp;
   assign bus.dataout  = dout;
   assign bus.busy     = (state != IDLE);
   assign bus.err      = err;
endmodule

// File: tb/tb_sys_mem_ctrl.sv
// Directed bench for sys_mem_ctrl: transaction-level model predicts the
// handshake timing and storage contents, checked every cycle.
module tb_sys_mem_ctrl;
   localparam int ADDR_W = 14;
   localparam int RD_LAT = 3;
   localparam int WR_LAT = 3;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   sys_mem_if #(.ADDR_W(ADDR_W)) bus ();

   sys_mem_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   logic       chk_en   = 1'b0;
   logic       exp_resp = 1'b0;
   logic       exp_busy = 1'b0;
   logic       exp_err  = 1'b0;
   logic [7:0] exp_dout = 8'h00;
   logic       lit_en   = 1'b0;
   logic [7:0] lit_exp  = 8'h00;

   logic [7:0] mm [logic [ADDR_W-1:0]];

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("mem_resp", 8'(bus.mem_resp), 8'(exp_resp));
         chk("busy",     8'(bus.busy),     8'(exp_busy));
         chk("err",      8'(bus.err),      8'(exp_err));
         chk("dataout",  bus.dataout,      exp_dout);
         if (lit_en) chk("dataout_literal", bus.dataout, lit_exp);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      exp_err = 1'b0;
   endtask

   task automatic lit(input logic [7:0] v);
      lit_exp = v;
      lit_en  = 1'b1;
      step();
      lit_en  = 1'b0;
   endtask

   // Full transaction; request is dropped 'hold' cycles after mem_resp rises.
   task automatic txn(input bit wr, input logic [ADDR_W-1:0] a, input logic [15:0] d,
                      input int hold);
      int lat;
      lat = wr ? WR_LAT : RD_LAT;
      bus.read_req  = !wr;
      bus.write_req = wr;
      bus.addrin    = a;
      bus.datain    = d;
      step();
      exp_busy   = 1'b1;
      bus.addrin = ~a;
      bus.datain = ~d;
      repeat (lat - 1) step();
      step();
      exp_resp = 1'b1;
      if (wr) begin
         mm[a]                                  = d[7:0];
         mm[a + {{(ADDR_W-1){1'b0}}, 1'b1}]     = d[15:8];
      end else begin
         exp_dout = mm[a];
      end
      repeat (hold) step();
      bus.read_req  = 1'b0;
      bus.write_req = 1'b0;
      step();
      exp_resp = 1'b0;
      exp_busy = 1'b0;
   endtask

   initial begin
      bus.read_req  = 1'b0;
      bus.write_req = 1'b0;
      bus.addrin    = '0;
      bus.datain    = 16'h0000;

      // reset for two edges
      step();
      chk_en = 1'b1;
      lit(8'h00);
      reset_n = 1'b1;
      step();

      // basic write then byte reads, one read with request already low at RESP
      txn(1'b1, 14'h0100, 16'hBEEF, 1);
      txn(1'b0, 14'h0100, 16'h0000, 1);
      lit(8'hEF);
      txn(1'b0, 14'h0101, 16'h0000, 0);
      lit(8'hBE);

      // wrap of the high byte
      txn(1'b1, 14'h3FFF, 16'h1234, 1);
      txn(1'b0, 14'h3FFF, 16'h0000, 1);
      lit(8'h34);
      txn(1'b0, 14'h0000, 16'h0000, 2);
      lit(8'h12);

      // both requests high: error pulse, no access
      bus.addrin    = 14'h0000;
      bus.datain    = 16'hFFFF;
      bus.read_req  = 1'b1;
      bus.write_req = 1'b1;
      step();
      exp_err       = 1'b1;
      bus.read_req  = 1'b0;
      bus.write_req = 1'b0;
      step();
      step();
      txn(1'b0, 14'h0101, 16'h0000, 1);
      txn(1'b0, 14'h0000, 16'h0000, 1);
      lit(8'h12);

      // request held for 10 cycles past mem_resp
      txn(1'b0, 14'h0101, 16'h0000, 10);
      lit(8'hBE);

      // reset one edge after a write is accepted
      txn(1'b1, 14'h0200, 16'h6655, 1);
      bus.write_req = 1'b1;
      bus.addrin    = 14'h0200;
      bus.datain    = 16'hAAAA;
      step();
      exp_busy      = 1'b1;
      reset_n       = 1'b0;
      bus.write_req = 1'b0;
      step();
      exp_busy = 1'b0;
      exp_dout = 8'h00;
      step();
      reset_n = 1'b1;
      repeat (6) step();
      txn(1'b0, 14'h0200, 16'h0000, 1);
      lit(8'h55);
      txn(1'b0, 14'h0201, 16'h0000, 1);
      lit(8'h66);

      repeat (2) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
